// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: word type, icodes, register ids, status codes and
// the destination-register selection helpers used by the write-back stage.
package y86_pkg;

    localparam int WORD_W = 64;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_e;

    function automatic logic [3:0] dst_e_sel(input logic [3:0] icode,
                                             input logic [3:0] rb,
                                             input logic       cnd);
        logic [3:0] dst;
        dst = RNONE;
        case (icode)
            CMOV:                  dst = cnd ? rb : RNONE;
            IRMOV, OPQ:            dst = rb;
            CALL, RET, PUSH, POP:  dst = RRSP;
            default:               dst = RNONE;
        endcase
        return dst;
    endfunction

    function automatic logic [3:0] dst_m_sel(input logic [3:0] icode,
                                             input logic [3:0] ra);
        logic [3:0] dst;
        dst = RNONE;
        if (icode == MRMOV || icode == POP) begin
            dst = ra;
        end
        return dst;
    endfunction

endpackage

// File: rtl/wb_pc_update_if.sv
// Bundle between the memory stage/decode and the write-back + PC stage.
// master = upstream datapath driving operands; slave = wb_pc_update.
interface wb_pc_update_if;
    import y86_pkg::*;

    logic [3:0] icode;
    logic [3:0] rA;
    logic [3:0] rB;
    logic       cnd;
    word_t      valE;
    word_t      valM;
    word_t      valC;
    word_t      valP;
    logic       instr_valid;
    logic       imem_error;
    logic       dmem_error;
    logic [3:0] srcA;
    logic [3:0] srcB;
    word_t      valA;
    word_t      valB;
    word_t      pc;
    logic [2:0] stat;
    logic       halted;

    modport master (
        output icode, rA, rB, cnd, valE, valM, valC, valP,
        output instr_valid, imem_error, dmem_error, srcA, srcB,
        input  valA, valB, pc, stat, halted
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, valC, valP,
        input  instr_valid, imem_error, dmem_error, srcA, srcB,
        output valA, valB, pc, stat, halted
    );

endinterface

// File: rtl/y86_regfile.sv
// Program register file: NREG x 64 storage, two async read ports, two
// synchronous write ports; port M overrides port E on the same register.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] src_a_i,
    input  logic [3:0] src_b_i,
    output word_t      val_a_o,
    output word_t      val_b_o,
    input  logic       we_e_i,
    input  logic [3:0] dst_e_i,
    input  word_t      val_e_i,
    input  logic       we_m_i,
    input  logic [3:0] dst_m_i,
    input  word_t      val_m_i
);

    localparam logic [3:0] NREG_ID = 4'(NREG);

    word_t regs_q [NREG];

    // M write is issued last so it wins when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we_e_i && (dst_e_i < NREG_ID)) begin
                regs_q[dst_e_i] <= val_e_i;
            end
            if (we_m_i && (dst_m_i < NREG_ID)) begin
                regs_q[dst_m_i] <= val_m_i;
            end
        end
    end

    always_comb begin
        val_a_o = '0;
        val_b_o = '0;
        if (src_a_i < NREG_ID) begin
            val_a_o = regs_q[src_a_i];
        end
        if (src_b_i < NREG_ID) begin
            val_b_o = regs_q[src_b_i];
        end
    end

endmodule

// File: rtl/wb_pc_update.sv
// Y86-64 SEQ write-back/PC stage: register commit, PC update and status FSM.
// Optional WB_RETIRE_COUNT_EN adds a retired-instruction counter output.
//
// state | meaning
// AOK   | running, commits every cycle
// HLT   | halt instruction reached, state frozen until rst
// ADR   | instruction or data address fault, state frozen until rst
// INS   | illegal instruction, state frozen until rst
module wb_pc_update
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          NREG     = 15
) (
    input  logic          clk,
    input  logic          rst,
`ifdef WB_RETIRE_COUNT_EN
    output logic [63:0]   retired_count,
`endif
    wb_pc_update_if.slave bus
);

    stat_e      stat_q, stat_d;
    word_t      pc_q, pc_d;
    word_t      next_pc;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       commit;

    assign dst_e = dst_e_sel(bus.icode, bus.rB, bus.cnd);
    assign dst_m = dst_m_sel(bus.icode, bus.rA);

    always_comb begin
        next_pc = bus.valP;
        case (bus.icode)
            CALL:    next_pc = bus.valC;
            JXX:     next_pc = bus.cnd ? bus.valC : bus.valP;
            RET:     next_pc = bus.valM;
            default: next_pc = bus.valP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= AOK;
            pc_q   <= RESET_PC;
        end else begin
            stat_q <= stat_d;
            pc_q   <= pc_d;
        end
    end

    // Any non-AOK status is sticky; only rst leaves it.
    always_comb begin
        stat_d = stat_q;
        pc_d   = pc_q;
        commit = 1'b0;
        if (stat_q == AOK) begin
            if (bus.imem_error || bus.dmem_error) begin
                stat_d = ADR;
            end else if (!bus.instr_valid) begin
                stat_d = INS;
            end else if (bus.icode == HALT) begin
                stat_d = HLT;
            end else begin
                stat_d = AOK;
                commit = 1'b1;
                pc_d   = next_pc;
            end
        end
    end

    y86_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .src_a_i (bus.srcA),
        .src_b_i (bus.srcB),
        .val_a_o (bus.valA),
        .val_b_o (bus.valB),
        .we_e_i  (commit && (dst_e != RNONE)),
        .dst_e_i (dst_e),
        .val_e_i (bus.valE),
        .we_m_i  (commit && (dst_m != RNONE)),
        .dst_m_i (dst_m),
        .val_m_i (bus.valM)
    );

    assign bus.pc     = pc_q;
    assign bus.stat   = stat_q;
    assign bus.halted = (stat_q != AOK);

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retired_q, retired_d;

    assign retired_d = commit ? retired_q + 64'd1 : retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_wb_pc_update.sv
// Scoreboard bench for wb_pc_update: directed instruction vectors push expected
// post-edge state; a monitor pops and compares one entry after each rising edge.
module tb_wb_pc_update;
    import y86_pkg::*;

    logic clk;
    logic rst;
    logic [63:0] retired_count;

    wb_pc_update_if bus();

`ifdef WB_RETIRE_COUNT_EN
    wb_pc_update dut (.clk(clk), .rst(rst), .retired_count(retired_count), .bus(bus));
`else
    wb_pc_update dut (.clk(clk), .rst(rst), .bus(bus));
    assign retired_count = '0;
`endif

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [2:0]  stat;
        logic        halted;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc", bus.pc, e.pc);
                chk(e.name, "stat", 64'(bus.stat), 64'(e.stat));
                chk(e.name, "halted", 64'(bus.halted), 64'(e.halted));
                chk(e.name, "valA", bus.valA, e.va);
                chk(e.name, "valB", bus.valB, e.vb);
`ifdef WB_RETIRE_COUNT_EN
                chk(e.name, "retired", retired_count, e.rc);
`endif
            end
        end
    end

    task automatic step(input string nm, input bit r, input logic [3:0] ic, ra, rb,
                        input bit c, input logic [63:0] ve, vm, vc, vp,
                        input bit iv, ie, de, input logic [3:0] sa, sb,
                        input logic [63:0] epc, input logic [2:0] est,
                        input logic [63:0] eva, evb, erc);
        exp_t e;
        rst              = r;
        bus.icode        = ic;
        bus.rA           = ra;
        bus.rB           = rb;
        bus.cnd          = c;
        bus.valE         = ve;
        bus.valM         = vm;
        bus.valC         = vc;
        bus.valP         = vp;
        bus.instr_valid  = iv;
        bus.imem_error   = ie;
        bus.dmem_error   = de;
        bus.srcA         = sa;
        bus.srcB         = sb;
        e.name   = nm;
        e.pc     = epc;
        e.stat   = est;
        e.halted = (est != 3'd1);
        e.va     = eva;
        e.vb     = evb;
        e.rc     = erc;
        exp_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    initial begin : stim
        int budget;
        step("reset0",      1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0,              1, 0, 0, 4'h2, 4'h4, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("irmovq",      0, 4'h3, 4'hF, 4'h2, 0, 64'h1234, 0, 0, 64'hA,   1, 0, 0, 4'h2, 4'h4, 64'hA,  3'd1, 64'h1234, 64'h0, 1);
        step("popq_rsp",    0, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'h55, 0, 64'hC, 1, 0, 0, 4'h4, 4'h2, 64'hC, 3'd1, 64'h55, 64'h1234, 2);
        step("jxx_taken",   0, 4'h7, 4'hF, 4'hF, 1, 0, 0, 64'h40, 64'h15,    1, 0, 0, 4'h4, 4'h2, 64'h40, 3'd1, 64'h55, 64'h1234, 3);
        step("jxx_nottaken",0, 4'h7, 4'hF, 4'hF, 0, 0, 0, 64'h40, 64'h19,    1, 0, 0, 4'h4, 4'h2, 64'h19, 3'd1, 64'h55, 64'h1234, 4);
        step("call",        0, 4'h8, 4'hF, 4'hF, 0, 64'h100, 0, 64'h80, 64'h22, 1, 0, 0, 4'h4, 4'h2, 64'h80, 3'd1, 64'h100, 64'h1234, 5);
        step("ret",         0, 4'h9, 4'hF, 4'hF, 0, 64'h108, 64'h13, 0, 64'h81, 1, 0, 0, 4'h4, 4'h2, 64'h13, 3'd1, 64'h108, 64'h1234, 6);
        step("cmov_nt",     0, 4'h2, 4'h2, 4'h3, 0, 64'h1234, 0, 0, 64'h15,  1, 0, 0, 4'h3, 4'h2, 64'h15, 3'd1, 64'h0, 64'h1234, 7);
        step("cmov_t",      0, 4'h2, 4'h2, 4'h3, 1, 64'h777, 0, 0, 64'h17,   1, 0, 0, 4'h3, 4'h2, 64'h17, 3'd1, 64'h777, 64'h1234, 8);
        step("opq",         0, 4'h6, 4'h1, 4'h2, 0, 64'hAAAA, 0, 0, 64'h19,  1, 0, 0, 4'h3, 4'h2, 64'h19, 3'd1, 64'h777, 64'hAAAA, 9);
        step("mrmov_dmem",  0, 4'h5, 4'h3, 4'hF, 0, 0, 64'hDEAD, 0, 64'h23,  1, 0, 1, 4'h3, 4'h2, 64'h19, 3'd3, 64'h777, 64'hAAAA, 9);
        step("adr_frozen1", 0, 4'h3, 4'hF, 4'h3, 0, 64'h1, 0, 0, 64'h50,     1, 0, 0, 4'h3, 4'h2, 64'h19, 3'd3, 64'h777, 64'hAAAA, 9);
        step("adr_frozen2", 0, 4'h3, 4'hF, 4'h2, 0, 64'h5, 0, 0, 64'h60,     0, 1, 0, 4'h3, 4'h2, 64'h19, 3'd3, 64'h777, 64'hAAAA, 9);
        step("reset_adr",   1, 4'h3, 4'hF, 4'h2, 0, 64'h5, 0, 0, 64'h60,     1, 0, 0, 4'h3, 4'h2, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("adr_over_ins",0, 4'h3, 4'hF, 4'h2, 0, 64'h5, 0, 0, 64'hA,      0, 1, 0, 4'h2, 4'h4, 64'h0,  3'd3, 64'h0, 64'h0, 0);
        step("reset_b",     1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0,              1, 0, 0, 4'h2, 4'h4, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("nop_imem",    0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 64'hA,          1, 1, 0, 4'h2, 4'h4, 64'h0,  3'd3, 64'h0, 64'h0, 0);
        step("reset_c",     1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0,              1, 0, 0, 4'h2, 4'hF, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("irmov_pre",   0, 4'h3, 4'hF, 4'h2, 0, 64'h9, 0, 0, 64'h2A,     1, 0, 0, 4'h2, 4'hF, 64'h2A, 3'd1, 64'h9, 64'h0, 1);
        step("halt",        0, 4'h0, 4'hF, 4'hF, 0, 0, 0, 0, 64'h2B,         1, 0, 0, 4'h2, 4'hF, 64'h2A, 3'd2, 64'h9, 64'h0, 1);
        step("hlt_frozen",  0, 4'h3, 4'hF, 4'h2, 0, 64'h3, 0, 0, 64'h40,     1, 0, 0, 4'h2, 4'hF, 64'h2A, 3'd2, 64'h9, 64'h0, 1);
        step("reset_d",     1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0,              1, 0, 0, 4'h2, 4'hF, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("ins",         0, 4'h3, 4'hF, 4'h2, 0, 64'h7, 0, 0, 64'hA,      0, 0, 0, 4'h2, 4'h3, 64'h0,  3'd4, 64'h0, 64'h0, 0);
        step("ins_frozen",  0, 4'h6, 4'hF, 4'h2, 0, 64'h8, 0, 0, 64'hB,      1, 0, 1, 4'h2, 4'h3, 64'h0,  3'd4, 64'h0, 64'h0, 0);
        step("reset_in_ins",1, 4'h6, 4'hF, 4'h2, 0, 64'h8, 0, 0, 64'hB,      1, 0, 0, 4'h2, 4'h3, 64'h0,  3'd1, 64'h0, 64'h0, 0);
        step("cnt_irmov1",  0, 4'h3, 4'hF, 4'h2, 0, 64'h11, 0, 0, 64'hA,     1, 0, 0, 4'h2, 4'h3, 64'hA,  3'd1, 64'h11, 64'h0, 1);
        step("cnt_irmov2",  0, 4'h3, 4'hF, 4'h3, 0, 64'h22, 0, 0, 64'h14,    1, 0, 0, 4'h2, 4'h3, 64'h14, 3'd1, 64'h11, 64'h22, 2);
        step("cnt_nop",     0, 4'h1, 4'hF, 4'hF, 0, 64'h99, 0, 0, 64'h15,    1, 0, 0, 4'h2, 4'h3, 64'h15, 3'd1, 64'h11, 64'h22, 3);
        step("cnt_halt",    0, 4'h0, 4'hF, 4'hF, 0, 0, 0, 0, 64'h16,         1, 0, 0, 4'h2, 4'h3, 64'h15, 3'd2, 64'h11, 64'h22, 3);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
